// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned BOOT_CNT_W = 4;
  localparam int unsigned WAIT_CNT_W = 8;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID source that matches a pending load
// destination in EX. Register 0 never creates a hazard.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             lu_hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match    = (ex_rd_i == id_rs_i);
  assign rt_match    = id_uses_rt_i && (ex_rd_i == id_rt_i);
  assign lu_hazard_o = ex_memread_i && (ex_rd_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: boot flush, load-use stall, branch flush and
// memory wait states. Optional watchdog enabled by PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_init,
  output logic             idex_en,
  output logic             idex_init,
  output logic             exmem_en,
  output logic             exmem_init,
  output logic             memwb_init,
  output logic [1:0]       state_o,
  output logic             mem_err
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(INIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic                  lu_hazard;
  logic                  freeze_c;

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_err_q, mem_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  logic [WAIT_CNT_W-1:0] unused_timeout;

  assign unused_timeout = WAIT_CNT_W'(MEM_TIMEOUT);
  assign mem_err        = 1'b0;
`endif

  hazard_detect u_hazard_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .lu_hazard_o  (lu_hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  assign state_o  = state_q;
  assign freeze_c = ((state_q == RUN) || (state_q == MEM_WAIT)) && mem_req && !mem_ready;

  // Next state plus stage controls; priority is freeze > branch > load-use.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
`ifdef PIPE_CTRL_WATCHDOG_EN
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
`endif
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_init  = 1'b0;
    idex_en    = 1'b1;
    idex_init  = 1'b0;
    exmem_en   = 1'b1;
    exmem_init = 1'b0;
    memwb_init = 1'b0;

    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          boot_cnt_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = MEM_WAIT;
`ifdef PIPE_CTRL_WATCHDOG_EN
          wait_cnt_d = '0;
`endif
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else begin
`ifdef PIPE_CTRL_WATCHDOG_EN
          if (wait_cnt_q == TIMEOUT_LAST) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if ((state_q == BOOT) || (state_q == HALT)) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_init  = 1'b1;
      idex_en    = 1'b0;
      idex_init  = 1'b1;
      exmem_en   = 1'b0;
      exmem_init = 1'b1;
      memwb_init = 1'b1;
    end else if (freeze_c) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_init = 1'b1;
    end else if (branch_taken) begin
      // ID content is flushed anyway, so a coincident load-use needs no stall.
      ifid_init = 1'b1;
      idex_init = 1'b1;
    end else if (lu_hazard) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_init = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed corner sequences
// and randomized traffic against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned INIT_C = 4;
  localparam int unsigned TMO    = 4;
`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // Output bit order: {pc_en, ifid_en, ifid_init, idex_en, idex_init, exmem_en, exmem_init, memwb_init}
  localparam logic [7:0] O_NORM   = 8'b1101_0100;
  localparam logic [7:0] O_LU     = 8'b0001_1100;
  localparam logic [7:0] O_BR     = 8'b1111_1100;
  localparam logic [7:0] O_FREEZE = 8'b0000_0001;
  localparam logic [7:0] O_BOOT   = 8'b0010_1011;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, ifid_init, idex_en, idex_init, exmem_en, exmem_init, memwb_init;
  logic [1:0] state_o;
  logic       mem_err;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_boot, m_waitcnt;
  bit m_wait, m_halt, m_err;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       uses_rt, memread, branch, req, ready;
    logic [7:0] exp_outs;
  } vec_t;

  vec_t vecs[12];

  pipe_ctrl #(.INIT_CYCLES(INIT_C), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_init    (ifid_init),
    .idex_en      (idex_en),
    .idex_init    (idex_init),
    .exmem_en     (exmem_en),
    .exmem_init   (exmem_init),
    .memwb_init   (memwb_init),
    .state_o      (state_o),
    .mem_err      (mem_err)
  );

  assign outs = {pc_en, ifid_en, ifid_init, idex_en, idex_init, exmem_en, exmem_init, memwb_init};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic uses_rt, input logic memread, input logic branch,
                              input logic req, input logic ready, input logic [7:0] exp_outs);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.uses_rt = uses_rt; v.memread = memread;
    v.branch = branch; v.req = req; v.ready = ready; v.exp_outs = exp_outs;
    return v;
  endfunction

  // Expected stage controls straight from the rules, given the state code.
  function automatic logic [7:0] rule_outs(input int st);
    logic [7:0] o;
    bit hz;
    if (st == 0 || st == 3) return O_BOOT;
    if (mem_req && !mem_ready) return O_FREEZE;
    hz = ex_memread && (ex_rd != 5'd0) &&
         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    o = O_NORM;
    if (branch_taken) begin
      o[5] = 1'b1;
      o[3] = 1'b1;
    end else if (hz) begin
      o[7] = 1'b0;
      o[6] = 1'b0;
      o[3] = 1'b1;
    end
    return o;
  endfunction

  function automatic int m_state();
    if (m_halt) return 3;
    if (m_boot > 0) return 0;
    if (m_wait) return 2;
    return 1;
  endfunction

  task automatic m_reset();
    m_boot = INIT_C; m_wait = 0; m_halt = 0; m_err = 0; m_waitcnt = 0;
  endtask

  task automatic m_step();
    if (m_halt) begin
    end else if (m_boot > 0) begin
      m_boot--;
    end else if (m_wait) begin
      if (mem_ready) m_wait = 0;
      else if (WD && (m_waitcnt + 1 == int'(TMO))) begin
        m_halt = 1; m_err = 1; m_wait = 0;
      end else m_waitcnt++;
    end else if (mem_req && !mem_ready) begin
      m_wait = 1; m_waitcnt = 0;
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 0; ex_memread = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Reset, release at a falling edge and wait out the flush; returns at a falling edge in RUN.
  task automatic boot_to_run();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_C) @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_outs", outs, O_BOOT);
    chk("reset_state", 8'(state_o), 8'd0);
    chk("reset_err", 8'(mem_err), 8'd0);

    // Boot flush: exactly INIT_CYCLES edges, then RUN
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(INIT_C); i++) begin
      #1;
      chk("boot_outs", outs, O_BOOT);
      chk("boot_state", 8'(state_o), 8'd0);
      @(negedge clk);
    end
    #1;
    chk("first_run_outs", outs, O_NORM);
    chk("first_run_state", 8'(state_o), 8'd1);

    // Vector table applied in RUN
    vecs[0]  = mk(5'd0,  5'd0, 5'd0,  0, 0, 0, 0, 0, O_NORM);
    vecs[1]  = mk(5'd8,  5'd0, 5'd8,  0, 1, 0, 0, 0, O_LU);
    vecs[2]  = mk(5'd0,  5'd0, 5'd0,  1, 1, 0, 0, 0, O_NORM);
    vecs[3]  = mk(5'd3,  5'd8, 5'd8,  0, 1, 0, 0, 0, O_NORM);
    vecs[4]  = mk(5'd3,  5'd8, 5'd8,  1, 1, 0, 0, 0, O_LU);
    vecs[5]  = mk(5'd8,  5'd0, 5'd8,  0, 0, 0, 0, 0, O_NORM);
    vecs[6]  = mk(5'd1,  5'd2, 5'd3,  0, 0, 1, 0, 0, O_BR);
    vecs[7]  = mk(5'd5,  5'd0, 5'd5,  0, 1, 1, 0, 0, O_BR);
    vecs[8]  = mk(5'd6,  5'd0, 5'd6,  0, 1, 0, 1, 1, O_LU);
    vecs[9]  = mk(5'd0,  5'd0, 5'd0,  0, 0, 1, 1, 1, O_BR);
    vecs[10] = mk(5'd4,  5'd0, 5'd0,  1, 1, 0, 0, 0, O_NORM);
    vecs[11] = mk(5'd31, 5'd0, 5'd31, 0, 1, 0, 0, 0, O_LU);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
      id_uses_rt = vecs[i].uses_rt; ex_memread = vecs[i].memread;
      branch_taken = vecs[i].branch; mem_req = vecs[i].req; mem_ready = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_outs", i), outs, vecs[i].exp_outs);
      chk($sformatf("vec%0d_state", i), 8'(state_o), 8'd1);
      @(negedge clk);
    end

    // Load-use for one cycle only, then the pipeline moves again
    clear_inputs();
    ex_memread = 1; ex_rd = 5'd8; id_rs = 5'd8;
    #1 chk("lu_bubble", outs, O_LU);
    @(negedge clk);
    clear_inputs();
    #1 chk("lu_after", outs, O_NORM);
    @(negedge clk);

    // Memory wait: 3 late cycles, hazards ignored while frozen, no dead release cycle
    mem_req = 1; mem_ready = 0;
    #1 chk("mw0_outs", outs, O_FREEZE);
    chk("mw0_state", 8'(state_o), 8'd1);
    @(negedge clk);
    #1 chk("mw1_outs", outs, O_FREEZE);
    chk("mw1_state", 8'(state_o), 8'd2);
    @(negedge clk);
    branch_taken = 1; ex_memread = 1; ex_rd = 5'd2; id_rs = 5'd2;
    #1 chk("mw2_outs_masked", outs, O_FREEZE);
    chk("mw2_state", 8'(state_o), 8'd2);
    @(negedge clk);
    mem_ready = 1;
    #1 chk("mw_release_outs", outs, O_BR);
    chk("mw_release_state", 8'(state_o), 8'd2);
    @(negedge clk);
    clear_inputs();
    #1 chk("mw_after_outs", outs, O_NORM);
    chk("mw_after_state", 8'(state_o), 8'd1);

    // Reset in the middle of MEM_WAIT takes effect without a clock edge
    @(negedge clk);
    mem_req = 1; mem_ready = 0;
    @(negedge clk);
    #1 chk("mwr_state_pre", 8'(state_o), 8'd2);
    #2 rst_n = 1'b0;
    #1 chk("mwr_outs", outs, O_BOOT);
    chk("mwr_state", 8'(state_o), 8'd0);

`ifdef PIPE_CTRL_WATCHDOG_EN
    // Watchdog timeout into HALT
    boot_to_run();
    mem_req = 1; mem_ready = 0;
    @(negedge clk);
    for (int i = 0; i < int'(TMO); i++) begin
      #1 chk("wd_wait_state", 8'(state_o), 8'd2);
      chk("wd_wait_err", 8'(mem_err), 8'd0);
      @(negedge clk);
    end
    #1 chk("wd_halt_state", 8'(state_o), 8'd3);
    chk("wd_halt_err", 8'(mem_err), 8'd1);
    chk("wd_halt_outs", outs, O_BOOT);
    mem_ready = 1;
    @(negedge clk);
    #1 chk("wd_halt_sticky", 8'(state_o), 8'd3);
    rst_n = 1'b0;
    #1 chk("wd_rst_err", 8'(mem_err), 8'd0);
    chk("wd_rst_state", 8'(state_o), 8'd0);

    // Ready on the last allowed cycle completes normally
    boot_to_run();
    mem_req = 1; mem_ready = 0;
    repeat (TMO) @(negedge clk);
    mem_ready = 1;
    #1 chk("wd_edge_outs", outs, O_NORM);
    @(negedge clk);
    clear_inputs();
    #1 chk("wd_edge_state", 8'(state_o), 8'd1);
    chk("wd_edge_err", 8'(mem_err), 8'd0);
`else
    // Without the watchdog a long wait never halts
    boot_to_run();
    mem_req = 1; mem_ready = 0;
    repeat (TMO * 3) @(negedge clk);
    #1 chk("nowd_state", 8'(state_o), 8'd2);
    chk("nowd_err", 8'(mem_err), 8'd0);
    mem_ready = 1;
    @(negedge clk);
    clear_inputs();
    #1 chk("nowd_release", 8'(state_o), 8'd1);
`endif

    // Randomized traffic against the reference model
    boot_to_run();
    m_reset();
    m_boot = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 3) begin
        rst_n = 1'b0;
        m_reset();
      end else begin
        rst_n = 1'b1;
      end
      id_rs        = 5'($urandom_range(3));
      id_rt        = 5'($urandom_range(3));
      ex_rd        = 5'($urandom_range(3));
      id_uses_rt   = 1'($urandom_range(1));
      ex_memread   = 1'($urandom_range(1));
      branch_taken = ($urandom_range(3) == 0);
      mem_req      = ($urandom_range(2) == 0);
      mem_ready    = 1'($urandom_range(1));
      #1;
      chk("rnd_outs", outs, rule_outs(m_state()));
      chk("rnd_state", 8'(state_o), 8'(m_state()));
      chk("rnd_err", 8'(mem_err), 8'(m_err));
      @(posedge clk);
      if (rst_n) m_step();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS-subset core. It drives the enable and `init` (synchronous clear-to-bubble) inputs of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It owns the following behaviours:
- post-reset pipeline flush;
- load-use stalls;
- taken-branch flushes;
- data-memory wait states, with an optional watchdog.

## Interface
Parameters:
- `INIT_CYCLES`, 4: cycles of full-pipeline flush after reset release (range 1..15).
- `MEM_TIMEOUT`, 16: maximum consecutive memory wait cycles before error (range 2..255; used only with the watchdog).

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt as a source.
- `ex_memread` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `branch_taken` in 1: branch resolved taken in EX this cycle.
- `mem_req` in 1: the MEM stage is accessing data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en` out 1: PC update enable.
- `ifid_en` out 1: IF/ID write enable.
- `ifid_init` out 1: IF/ID clear.
- `idex_en` out 1: ID/EX write enable.
- `idex_init` out 1: ID/EX clear.
- `exmem_en` out 1: EX/MEM write enable.
- `exmem_init` out 1: EX/MEM clear.
- `memwb_init` out 1: MEM/WB clear.
- `state_o` out 2: current FSM state encoding.
- `mem_err` out 1: sticky watchdog error flag.

## Operation
- FSM states and encodings: BOOT=0, RUN=1, MEM_WAIT=2, HALT=3.

Next-state logic:
- **BOOT:** 4-bit counter increments each cycle. When the counter equals `INIT_CYCLES-1`, the next state is RUN.
- **RUN:** if `mem_req && !mem_ready`, the next state is MEM_WAIT. Otherwise it stays in RUN.
- **MEM_WAIT:** if `mem_ready`, the next state is RUN. Otherwise it stays in MEM_WAIT.
- **HALT:** absorbing until reset.

Outputs are combinational from the state and inputs. Default (RUN, no hazard): all `*_en` = 1, all `*_init` = 0.

Output overrides by state and condition:
- **BOOT or HALT:** all `*_en` = 0 and all `*_init` = 1.
- **freeze** = (RUN or MEM_WAIT) && `mem_req` && !`mem_ready`. On freeze: `pc_en`, `ifid_en`, `idex_en` and `exmem_en` = 0; `memwb_init` = 1; other `init` outputs = 0.
- **Load-use hazard (not freeze):** the hazard exists when `ex_memread` && `ex_rd` != 0 && (`ex_rd` == `id_rs` || (`id_uses_rt` && `ex_rd` == `id_rt`)). Response: `pc_en` = 0, `ifid_en` = 0, `idex_init` = 1.
- **Branch flush (not freeze):** when `branch_taken`, `ifid_init` = 1 and `idex_init` = 1.

Priority and simultaneous events:
- freeze > branch > load-use.
- If freeze is active, `branch_taken` and the load-use hazard are ignored. EX is held, so both are re-evaluated on the release cycle.
- If branch and load-use occur together, the branch wins: `pc_en` = 1, because the instruction in ID is flushed anyway.
- A register 0 destination never stalls.

Other rules:
- On the release cycle in MEM_WAIT (`mem_ready` = 1), outputs follow the RUN rules, so there are no dead cycles.
- `mem_err` resets to 0 and is set only by the watchdog.

## Timing
- Reset values (`rst_n` = 0, asynchronous): state = BOOT, counters = 0, `mem_err` = 0. Outputs are therefore immediately `pc_en`/`*_en` = 0 and all `*_init` = 1.
- After `rst_n` rises, the flush lasts exactly `INIT_CYCLES` rising edges. The first RUN cycle follows.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 flushed slots. Memory wait costs N stall cycles for an N-cycle-late `mem_ready`.
- Reset asserted mid-operation (any state) returns the FSM to BOOT asynchronously and clears `mem_err`.

## Configuration
Macro: `PIPE_CTRL_WATCHDOG_EN`.
- **Defined:**
  - An 8-bit wait counter clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT while `mem_ready` = 0.
  - When the counter reaches `MEM_TIMEOUT-1` with `mem_ready` still 0, the next state is HALT and `mem_err` is set to 1 (sticky).
  - If `mem_ready` arrives on that same cycle, the access completes normally.
- **Undefined:** no wait counter, HALT is unreachable, `mem_err` is tied to 0, and MEM_WAIT waits indefinitely.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum (BOOT/RUN/MEM_WAIT/HALT) and its 2-bit encoding;
  - the `REG_ZERO` constant (5'd0).
- One sub-module, `hazard_detect`: the purely combinational load-use comparator producing `lu_hazard`.
- FSM, counters and output priority logic stay in `pipe_ctrl`.

## Test plan
- **Boot flush:** `INIT_CYCLES`=4, release `rst_n` → all `init` = 1 and `pc_en` = 0 for 4 edges; `state_o` = 1 on the 5th cycle with all enables = 1.
- **Load-use:** `ex_memread`=1, `ex_rd`=8, `id_rs`=8 → exactly one cycle of `pc_en`=0, `ifid_en`=0, `idex_init`=1. Repeat with `ex_rd`=0 → no stall.
- **Branch + load-use together:** `branch_taken`=1 with a hazard present → `ifid_init`=1, `idex_init`=1, `pc_en`=1.
- **Memory wait:** `mem_req`=1 with `mem_ready` low for 3 cycles → 3 cycles of all `*_en`=0 and `memwb_init`=1, `state_o`=2. Release cycle → `state_o` back to 1, no extra bubble.
- **Watchdog (macro defined):** `MEM_TIMEOUT`=4, `mem_ready` held 0 → HALT with `mem_err`=1 and all `init`=1. `rst_n` pulse → `mem_err`=0, state BOOT.
- **Mid-wait reset:** assert `rst_n`=0 during MEM_WAIT → immediate BOOT outputs without waiting for a clock edge.
